// File: rtl/vga_pkg.sv
// Pixel format definitions and per-format channel widths.
`timescale 1ns/1ps
package vga_pkg;

    typedef enum logic [1:0] {
        PIX_RGB565 = 2'd0,
        PIX_RGB555 = 2'd1,
        PIX_RGB444 = 2'd2,
        PIX_RGB332 = 2'd3
    } pix_fmt_e;

    // Red channel width for a packed format (0 marks an unknown format).
    function automatic int fmt_r_w(input pix_fmt_e f);
        case (f)
            PIX_RGB565: return 5;
            PIX_RGB555: return 5;
            PIX_RGB444: return 4;
            PIX_RGB332: return 3;
            default:    return 0;
        endcase
    endfunction

    // Green channel width for a packed format.
    function automatic int fmt_g_w(input pix_fmt_e f);
        case (f)
            PIX_RGB565: return 6;
            PIX_RGB555: return 5;
            PIX_RGB444: return 4;
            PIX_RGB332: return 3;
            default:    return 0;
        endcase
    endfunction

    // Blue channel width for a packed format.
    function automatic int fmt_b_w(input pix_fmt_e f);
        case (f)
            PIX_RGB565: return 5;
            PIX_RGB555: return 5;
            PIX_RGB444: return 4;
            PIX_RGB332: return 2;
            default:    return 0;
        endcase
    endfunction

    function automatic bit fmt_legal(input pix_fmt_e f);
        return (fmt_r_w(f) != 0) && (fmt_g_w(f) != 0) && (fmt_b_w(f) != 0);
    endfunction

endpackage

// File: rtl/pix_chan_expand.sv
// Combinational expansion of one colour channel from IN_W to OUT_W bits,
// either by repeating the input bits MSB-first or by zero padding the LSBs.
`timescale 1ns/1ps
module pix_chan_expand #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  chan_i,
    input  logic             mode_i,
    output logic [OUT_W-1:0] chan_o
);

    if (IN_W < 1 || IN_W > OUT_W) begin : g_bad_width
        $error("pix_chan_expand: IN_W must be in 1..OUT_W");
    end

    logic [OUT_W-1:0] rep;
    logic [OUT_W-1:0] pad;

    // Output bit k from the MSB takes input bit (k mod IN_W) from the MSB.
    always_comb begin
        rep = '0;
        for (int k = 0; k < OUT_W; k++) begin
            rep[OUT_W-1-k] = chan_i[IN_W-1-(k % IN_W)];
        end
    end

    // Input channel in the MSBs, zeros below.
    always_comb begin
        pad = '0;
        pad[OUT_W-1 -: IN_W] = chan_i;
    end

    assign chan_o = mode_i ? pad : rep;

endmodule

// File: rtl/pixel_expand_stream.sv
// Two-stage streaming pixel expander: S1 holds unpacked channels with their
// mode and sideband, S2 holds the expanded {R,G,B} word.
//
// Handshake: on both ports a beat transfers on a rising clk edge where valid
// and ready are both high. A producer holds valid and its payload until the
// transfer; ready may depend combinationally on downstream ready.
`timescale 1ns/1ps
module pixel_expand_stream
    import vga_pkg::*;
#(
    parameter pix_fmt_e IN_FMT = PIX_RGB565,
    parameter int       OUT_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [15:0]        in_data_i,
    input  logic               in_sof_i,
    input  logic               in_eol_i,
    input  logic               expand_mode_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [3*OUT_W-1:0] out_data_o,
    output logic               out_sof_o,
    output logic               out_eol_o
);

    localparam int R_W = fmt_r_w(IN_FMT);
    localparam int G_W = fmt_g_w(IN_FMT);
    localparam int B_W = fmt_b_w(IN_FMT);

    if (OUT_W != 8 && OUT_W != 10) begin : g_bad_out_w
        $error("pixel_expand_stream: OUT_W must be 8 or 10");
    end
    if (!fmt_legal(IN_FMT)) begin : g_bad_fmt
        $error("pixel_expand_stream: unsupported IN_FMT");
    end

    // Bits above the packed pixel are ignored by design.
    logic unused_in;
    assign unused_in = ^in_data_i;

    logic [R_W-1:0] in_r;
    logic [G_W-1:0] in_g;
    logic [B_W-1:0] in_b;
    assign in_b = in_data_i[0 +: B_W];
    assign in_g = in_data_i[B_W +: G_W];
    assign in_r = in_data_i[B_W+G_W +: R_W];

    logic           s1_valid_q, s1_valid_d;
    logic [R_W-1:0] s1_r_q, s1_r_d;
    logic [G_W-1:0] s1_g_q, s1_g_d;
    logic [B_W-1:0] s1_b_q, s1_b_d;
    logic           s1_mode_q, s1_mode_d;
    logic           s1_sof_q, s1_sof_d;
    logic           s1_eol_q, s1_eol_d;

    logic               s2_valid_q, s2_valid_d;
    logic [3*OUT_W-1:0] s2_data_q, s2_data_d;
    logic               s2_sof_q, s2_sof_d;
    logic               s2_eol_q, s2_eol_d;

    logic s1_en;
    logic s2_en;
    assign s2_en = !s2_valid_q || out_ready_i;
    assign s1_en = !s1_valid_q || s2_en;

    logic [OUT_W-1:0] exp_r, exp_g, exp_b;

    pix_chan_expand #(.IN_W(R_W), .OUT_W(OUT_W)) u_exp_r (
        .chan_i(s1_r_q), .mode_i(s1_mode_q), .chan_o(exp_r)
    );
    pix_chan_expand #(.IN_W(G_W), .OUT_W(OUT_W)) u_exp_g (
        .chan_i(s1_g_q), .mode_i(s1_mode_q), .chan_o(exp_g)
    );
    pix_chan_expand #(.IN_W(B_W), .OUT_W(OUT_W)) u_exp_b (
        .chan_i(s1_b_q), .mode_i(s1_mode_q), .chan_o(exp_b)
    );

    // Next state: each stage loads when enabled, otherwise holds its contents.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_r_d     = s1_r_q;
        s1_g_d     = s1_g_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        s1_sof_d   = s1_sof_q;
        s1_eol_d   = s1_eol_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_sof_d   = s2_sof_q;
        s2_eol_d   = s2_eol_q;
        if (s1_en) begin
            s1_valid_d = in_valid_i;
            s1_r_d     = in_r;
            s1_g_d     = in_g;
            s1_b_d     = in_b;
            s1_mode_d  = expand_mode_i;
            s1_sof_d   = in_sof_i;
            s1_eol_d   = in_eol_i;
        end
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = {exp_r, exp_g, exp_b};
            s2_sof_d   = s1_sof_q;
            s2_eol_d   = s1_eol_q;
        end
    end

    // Stage registers; reset drops everything in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
            s1_g_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sof_q   <= 1'b0;
            s2_eol_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_r_q     <= s1_r_d;
            s1_g_q     <= s1_g_d;
            s1_b_q     <= s1_b_d;
            s1_mode_q  <= s1_mode_d;
            s1_sof_q   <= s1_sof_d;
            s1_eol_q   <= s1_eol_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_sof_q   <= s2_sof_d;
            s2_eol_q   <= s2_eol_d;
        end
    end

    assign in_ready_o  = s1_en;
    assign out_valid_o = s2_valid_q;
    assign out_data_o  = s2_data_q;
    assign out_sof_o   = s2_sof_q;
    assign out_eol_o   = s2_eol_q;

endmodule

// File: tb/tb_pixel_expand_stream.sv
// Bench for pixel_expand_stream: three instances (565/8, 332/8, 565/10) share
// one stimulus stream; a scoreboard predicts each instance's output.
`timescale 1ns/1ps
module tb_pixel_expand_stream;
    import vga_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni    = 1'b0;
    logic        in_valid  = 1'b0;
    logic [15:0] in_data   = '0;
    logic        in_sof    = 1'b0;
    logic        in_eol    = 1'b0;
    logic        mode      = 1'b0;
    logic        out_ready = 1'b1;

    logic        rdy565, rdy332, rdy10;
    logic        v565, v332, v10;
    logic [23:0] d565, d332;
    logic [29:0] d10;
    logic        sof565, eol565, sof332, eol332, sof10, eol10;

    pixel_expand_stream #(.IN_FMT(PIX_RGB565), .OUT_W(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid), .in_ready_o(rdy565),
        .in_data_i(in_data), .in_sof_i(in_sof), .in_eol_i(in_eol),
        .expand_mode_i(mode), .out_valid_o(v565), .out_ready_i(out_ready),
        .out_data_o(d565), .out_sof_o(sof565), .out_eol_o(eol565)
    );

    pixel_expand_stream #(.IN_FMT(PIX_RGB332), .OUT_W(8)) u_dut332 (
        .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid), .in_ready_o(rdy332),
        .in_data_i(in_data), .in_sof_i(in_sof), .in_eol_i(in_eol),
        .expand_mode_i(mode), .out_valid_o(v332), .out_ready_i(out_ready),
        .out_data_o(d332), .out_sof_o(sof332), .out_eol_o(eol332)
    );

    pixel_expand_stream #(.IN_FMT(PIX_RGB565), .OUT_W(10)) u_dut10 (
        .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid), .in_ready_o(rdy10),
        .in_data_i(in_data), .in_sof_i(in_sof), .in_eol_i(in_eol),
        .expand_mode_i(mode), .out_valid_o(v10), .out_ready_i(out_ready),
        .out_data_o(d10), .out_sof_o(sof10), .out_eol_o(eol10)
    );

    // ---------------- counters and check ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [9:0] ref_chan(input int v, input int iw, input int ow, input logic m);
        int acc;
        int filled;
        if (m) return 10'(v << (ow - iw));
        acc    = 0;
        filled = 0;
        while (filled < ow) begin
            acc    = (acc << iw) | v;
            filled = filled + iw;
        end
        return 10'(acc >> (filled - ow));
    endfunction

    // is332: 332 packing, else 565. Result is {R,G,B} right-aligned.
    function automatic logic [29:0] ref_pix(input bit is332, input int ow,
                                            input logic [15:0] d, input logic m);
        int r, g, b, rw, gw, bw;
        logic [9:0] er, eg, eb;
        if (is332) begin
            r = int'(d[7:5]); g = int'(d[4:2]); b = int'(d[1:0]);
            rw = 3; gw = 3; bw = 2;
        end else begin
            r = int'(d[15:11]); g = int'(d[10:5]); b = int'(d[4:0]);
            rw = 5; gw = 6; bw = 5;
        end
        er = ref_chan(r, rw, ow, m);
        eg = ref_chan(g, gw, ow, m);
        eb = ref_chan(b, bw, ow, m);
        if (ow == 8) return {6'b0, er[7:0], eg[7:0], eb[7:0]};
        return {er, eg, eb};
    endfunction

    // ---------------- scoreboard ----------------
    logic [31:0] exp565_q[$];
    logic [31:0] exp332_q[$];
    logic [31:0] exp10_q[$];

    // Reset discards everything in flight, so predictions go too.
    always @(posedge clk) begin
        if (!rst_ni) begin
            exp565_q.delete();
            exp332_q.delete();
            exp10_q.delete();
        end
    end

    // Mid-cycle: compare beats that will transfer, then record accepted inputs.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_ni) begin
            if (v565 && out_ready) begin
                check("sb565_expected", 32'(exp565_q.size() != 0), 32'd1);
                if (exp565_q.size() != 0) begin
                    e = exp565_q.pop_front();
                    check("sb565", {sof565, eol565, 6'b0, d565}, e);
                end
            end
            if (v332 && out_ready) begin
                check("sb332_expected", 32'(exp332_q.size() != 0), 32'd1);
                if (exp332_q.size() != 0) begin
                    e = exp332_q.pop_front();
                    check("sb332", {sof332, eol332, 6'b0, d332}, e);
                end
            end
            if (v10 && out_ready) begin
                check("sb10_expected", 32'(exp10_q.size() != 0), 32'd1);
                if (exp10_q.size() != 0) begin
                    e = exp10_q.pop_front();
                    check("sb10", {sof10, eol10, d10}, e);
                end
            end
            if (in_valid && rdy565) begin
                exp565_q.push_back({in_sof, in_eol, ref_pix(1'b0, 8, in_data, mode)});
                exp332_q.push_back({in_sof, in_eol, ref_pix(1'b1, 8, in_data, mode)});
                exp10_q.push_back({in_sof, in_eol, ref_pix(1'b0, 10, in_data, mode)});
            end
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic drive_pix(input logic [15:0] d, input logic m, input logic s, input logic e);
        logic acc;
        in_data  = d;
        mode     = m;
        in_sof   = s;
        in_eol   = e;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = rdy565;
            @(posedge clk);
            #1;
        end
        check("accept", 32'(acc), 32'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
    endtask

    // One pixel into an empty pipe; returns at the negedge where it is on the output.
    task automatic single(input logic [15:0] d, input logic m);
        in_data  = d;
        mode     = m;
        in_valid = 1'b1;
        @(negedge clk);
        check("single_ready", 32'(rdy565), 32'd1);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        check("latency_1", 32'(v565), 32'd0);
        @(negedge clk);
        check("latency_2", 32'(v565), 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && (exp565_q.size() + exp332_q.size() + exp10_q.size()) != 0; n++)
            @(negedge clk);
        check("drain565", 32'(exp565_q.size()), 32'd0);
        check("drain332", 32'(exp332_q.size()), 32'd0);
        check("drain10", 32'(exp10_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        done;
        logic [23:0] held;
        logic        saw_low;
        int          early_valid;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(v565), 32'd0);
        check("rst_out_data", 32'(d565), 32'd0);
        check("rst_out_sb", {30'b0, sof565, eol565}, 32'd0);
        check("rst_out_data10", 32'(d10), 32'd0);
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(rdy565), 32'd1);
        @(posedge clk);
        #1;

        // Directed values with latency
        single(16'hF800, 1'b0);
        check("r565_rep_F800", 32'(d565), 32'hFF0000);
        @(posedge clk); #1;
        single(16'hFFFF, 1'b1);
        check("r565_pad_FFFF", 32'(d565), 32'hF8FCF8);
        @(posedge clk); #1;
        single(16'h0056, 1'b0);
        check("r332_rep_0056", 32'(d332), 32'h49B6AA);
        @(posedge clk); #1;
        single(16'hFFFF, 1'b0);
        check("r10_rep_FFFF", 32'(d10), 32'h3FFFFFFF);
        @(posedge clk); #1;
        single(16'h0000, 1'b0);
        check("r10_rep_0000", 32'(d10), 32'h0);
        @(posedge clk); #1;
        drain();

        // Full-throughput stream with a mid-stream mode change
        for (int i = 0; i < 8; i++)
            drive_pix(16'($urandom), (i >= 4), (i == 0), (i == 7));
        idle();
        drain();

        // Random stream with random output backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++)
                    drive_pix(16'($urandom), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Backpressure: six pixels, stall output 3 cycles after the first beat
        @(posedge clk); #1;
        saw_low = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    drive_pix(16'($urandom), 1'b0, (i == 0), (i == 5));
                idle();
            end
            begin
                for (int n = 0; n < 50 && !v565; n++) @(negedge clk);
                check("bp_first_out", 32'(v565), 32'd1);
                @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                held = d565;
                saw_low = !rdy565;
                @(posedge clk); #1;
                @(negedge clk);
                check("bp_stable_1", 32'(d565), 32'(held));
                @(posedge clk); #1;
                @(negedge clk);
                check("bp_stable_2", 32'(d565), 32'(held));
                check("bp_valid_held", 32'(v565), 32'd1);
                check("bp_in_ready_low", 32'(saw_low && !rdy565), 32'd1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages full
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive_pix(16'h1234, 1'b0, 1'b1, 1'b0);
        drive_pix(16'hABCD, 1'b1, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        check("full_in_ready", 32'(rdy565), 32'd0);
        check("full_out_valid", 32'(v565), 32'd1);
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        rst_ni    = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(v565), 32'd0);
        check("post_rst_ready", 32'(rdy565), 32'd1);
        early_valid = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (v565 || v332 || v10) early_valid++;
        end
        check("no_stale_pixels", 32'(early_valid), 32'd0);

        // Stream after reset recovers normally
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++)
            drive_pix(16'($urandom), 1'($urandom_range(0, 1)), (i == 0), (i == 3));
        idle();
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #500000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pixel_expand_stream.md
PIXEL_EXPAND_STREAM -- requirements
Module: pixel_expand_stream

Interface
REQ-001 SHALL have parameter IN_FMT, default PIX_RGB565, selecting the input packing: PIX_RGB565, PIX_RGB555, PIX_RGB444 or PIX_RGB332.
REQ-002 SHALL have parameter OUT_W, default 8, giving output bits per channel; legal values are 8 and 10.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid_i, input, 1 bit: an input pixel is present.
REQ-006 SHALL have port in_ready_o, output, 1 bit: the block accepts an input pixel this cycle.
REQ-007 SHALL have port in_data_i, input, 16 bits: packed pixel (see REQ-013).
REQ-008 SHALL have port in_sof_i / in_eol_i, input, 1 bit each: start-of-frame and end-of-line sideband.
REQ-009 SHALL have port expand_mode_i, input, 1 bit: 0 = MSB replication, 1 = zero padding.
REQ-010 SHALL have port out_valid_o / out_ready_i, output / input, 1 bit each: output handshake.
REQ-011 SHALL have port out_data_o, output, 3*OUT_W bits: {R,G,B}, with R in the MSBs.
REQ-012 SHALL have port out_sof_o / out_eol_o, output, 1 bit each: sideband aligned with out_data_o.

Function
REQ-013 Input packing SHALL be as follows:
- 565: R[15:11] G[10:5] B[4:0]
- 555: R[14:10] G[9:5] B[4:0]; bit 15 ignored
- 444: R[11:8] G[7:4] B[3:0]
- 332: R[7:5] G[4:2] B[1:0]
- Unused upper bits ignored.
REQ-014 A transfer SHALL occur on any clock edge where valid and ready are both high; the same rule applies on both ports.
REQ-015 The datapath SHALL be a two-stage register pipeline:
- S1 holds the unpacked channels, mode and sideband.
- S2 holds the expanded output.
- Latency is exactly 2 cycles from input transfer to out_valid_o while out_ready_i stays high.
REQ-016 Full throughput SHALL be one pixel per cycle under continuous valid/ready.
REQ-017 Stage enables SHALL be:
- s2_en = !s2_valid || out_ready_i
- s1_en = !s1_valid || s2_en
- in_ready_o = s1_en
REQ-018 Under backpressure, S1 and S2 SHALL hold their contents; there shall be no loss, no duplication, and order shall be preserved.
REQ-019 out_data_o, out_sof_o and out_eol_o SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-020 Replication mode SHALL set output bit k (counted from the MSB) to input bit (k mod IN_W) (counted from the MSB), per channel, where IN_W is that channel's input width.
REQ-021 Zero-pad mode SHALL place the input channel in the MSBs and fill the remaining bits with zeros.
REQ-022 expand_mode_i SHALL be sampled at input transfer and travel with its pixel, so a mode change mid-stream affects only later pixels.
REQ-023 Sideband bits SHALL travel with their pixel unmodified; in_sof_i and in_eol_i on the same pixel shall both propagate.
REQ-024 A simultaneous input transfer and output transfer SHALL be legal with both stages full, and in_ready_o shall stay 1 in that case.

Reset
REQ-025 While rst_ni=0 at a clock edge, the block SHALL clear s1_valid and s2_valid and zero all stage data, so out_valid_o=0, out_data_o=0, out_sof_o=0 and out_eol_o=0.
REQ-026 Pixels in flight at reset SHALL be discarded; none shall appear after release.
REQ-027 in_ready_o SHALL be 1 in the first cycle after reset release.

Structure
REQ-028 The pix_fmt_e enum and the per-format channel-width constants SHALL reside in vga_pkg.
REQ-029 Per-channel expansion SHALL be a combinational sub-module pix_chan_expand with parameters IN_W and OUT_W and a mode input, instantiated three times.
REQ-030 An illegal OUT_W or IN_FMT SHALL cause an elaboration-time error.

Verification
REQ-031 565, OUT_W=8, replicate, in 16'hF800, out_ready_i=1 -> out_data_o=24'hFF0000 exactly 2 cycles later.
REQ-032 565, OUT_W=8, zero-pad, in 16'hFFFF -> out_data_o=24'hF8FCF8.
REQ-033 332, replicate, in 16'h0056 -> out_data_o=24'h49B6AA.
REQ-034 565, OUT_W=10, replicate, in 16'hFFFF -> out_data_o=30'h3FFFFFFF; in 16'h0000 -> 30'h0.
REQ-035 Backpressure: stream 6 pixels with sof on pixel 0 and eol on pixel 5, hold out_ready_i=0 for 3 cycles after the first output -> in_ready_o falls once S1 and S2 are full; all 6 pixels emerge in order with correct sideband and no duplicates.
REQ-036 Reset mid-stream: assert rst_ni=0 for 1 cycle with S1 and S2 full -> next cycle out_valid_o=0 and in_ready_o=1, and no stale pixel is ever output.
